// File: rtl/ipf_feeder.sv
// ---------------------------------------------------------------------------
// ipf_feeder
//   Upstream sequencer for the IPF multiply engine. For one job it streams a
//   kernel's weight words, then a number of 16-row passes over an 8-row input
//   tile, then holds for a drain window, signals end to IPF and waits for IPF
//   to finish before pulsing done.
//
//   Ports
//     clk, rst                    clock (rising edge), async active-high reset
//     cfg_valid/cfg_ready         job handshake; cfg_ready high only when idle
//     cfg_wsize/stride/npass/pad  job configuration, latched on accept
//     w_rd_en/w_rd_addr/w_rd_data weight buffer port (1-cycle read latency)
//     i_rd_en/i_rd_addr/i_rd_data input buffer port (1-cycle read latency)
//     w_valid/w_data              weight stream to IPF
//     i_valid/i_data              input stream to IPF
//     ctrl                        to IPF: 0 end, 1 start, 2 hold
//     Wsize/stride/RLPadding      job-wide IPF settings
//     wgroup/wround               per-row weight selection for IPF
//     ipf_finish                  IPF completion, only honoured while ending
//     busy/done                   job in progress / one-cycle completion pulse
//
//   Reads are issued from the state/counters of cycle t. Every per-row IPF
//   field is registered, so it appears in t+1 alongside the buffer data.
// ---------------------------------------------------------------------------
module ipf_feeder #(
    parameter int DATA_W    = 64,
    parameter int W_ADDR_W  = 5,
    parameter int I_ADDR_W  = 3,
    parameter int ROWS      = 8,
    parameter int DRAIN_CYC = 10
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                cfg_valid,
    output logic                cfg_ready,
    input  logic                cfg_wsize,
    input  logic                cfg_stride,
    input  logic [3:0]          cfg_npass,
    input  logic [1:0]          cfg_pad,
    output logic                w_rd_en,
    output logic [W_ADDR_W-1:0] w_rd_addr,
    input  logic [DATA_W-1:0]   w_rd_data,
    output logic                i_rd_en,
    output logic [I_ADDR_W-1:0] i_rd_addr,
    input  logic [DATA_W-1:0]   i_rd_data,
    output logic                w_valid,
    output logic [DATA_W-1:0]   w_data,
    output logic                i_valid,
    output logic [DATA_W-1:0]   i_data,
    output logic [1:0]          ctrl,
    output logic [1:0]          Wsize,
    output logic                stride,
    output logic [3:0]          wgroup,
    output logic [2:0]          wround,
    output logic [1:0]          RLPadding,
    input  logic                ipf_finish,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_LOAD_W = 3'd1,
        S_PASS   = 3'd2,
        S_DRAIN  = 3'd3,
        S_END    = 3'd4
    } state_t;

    localparam logic [1:0] CTRL_END   = 2'd0;
    localparam logic [1:0] CTRL_START = 2'd1;
    localparam logic [1:0] CTRL_HOLD  = 2'd2;

    localparam int DRAIN_W = $clog2(DRAIN_CYC + 1);
    localparam logic [DRAIN_W-1:0]  DRAIN_LAST = DRAIN_W'(DRAIN_CYC - 1);
    localparam logic [W_ADDR_W-1:0] NW3_LAST   = W_ADDR_W'(17);
    localparam logic [W_ADDR_W-1:0] NW5_LAST   = W_ADDR_W'(24);

    state_t              state_r, state_next;
    logic [W_ADDR_W-1:0] w_cnt_r, w_cnt_next;
    logic [3:0]          row_r, row_next;
    logic [3:0]          k_r, k_next;
    logic [DRAIN_W-1:0]  drain_r, drain_next;

    logic                wsize_r, stride_r;
    logic [3:0]          npass_r;
    logic [1:0]          pad_r;

    logic                cfg_accept_s;
    logic [W_ADDR_W-1:0] nw_last_s;
    logic [3:0]          p_rows_s;
    logic                hold_row_s;
    logic [3:0]          k_inc_s;

    logic                w_valid_s, i_valid_s, done_s;
    logic [1:0]          ctrl_s;
    logic [3:0]          wgroup_s;
    logic [2:0]          wround_s;

    logic                w_valid_r, i_valid_r, done_r;
    logic [1:0]          ctrl_r;
    logic [3:0]          wgroup_r;
    logic [2:0]          wround_r;

    assign cfg_accept_s = cfg_valid && (state_r == S_IDLE);
    assign nw_last_s    = wsize_r ? NW5_LAST : NW3_LAST;
    assign p_rows_s     = wsize_r ? 4'd4 : 4'd2;
    assign hold_row_s   = (row_r < p_rows_s);
    assign k_inc_s      = k_r + 4'd1;

    // Next-state, counter updates and the cycle-t IPF field decisions.
    always_comb begin
        state_next = state_r;
        w_cnt_next = w_cnt_r;
        row_next   = row_r;
        k_next     = k_r;
        drain_next = drain_r;
        w_valid_s  = 1'b0;
        i_valid_s  = 1'b0;
        done_s     = 1'b0;
        ctrl_s     = CTRL_HOLD;
        wgroup_s   = 4'd0;
        wround_s   = 3'd0;
        case (state_r)
            S_IDLE: begin
                if (cfg_accept_s) begin
                    state_next = S_LOAD_W;
                    w_cnt_next = {W_ADDR_W{1'b0}};
                    row_next   = 4'd0;
                    k_next     = 4'd0;
                    drain_next = {DRAIN_W{1'b0}};
                end else begin
                    state_next = S_IDLE;
                end
            end
            S_LOAD_W: begin
                w_valid_s = 1'b1;
                if (w_cnt_r == nw_last_s) begin
                    w_cnt_next = {W_ADDR_W{1'b0}};
                    state_next = (npass_r == 4'd0) ? S_DRAIN : S_PASS;
                end else begin
                    w_cnt_next = w_cnt_r + W_ADDR_W'(1);
                end
            end
            S_PASS: begin
                i_valid_s = 1'b1;
                ctrl_s    = hold_row_s ? CTRL_HOLD : CTRL_START;
                if (stride_r) begin
                    // P is even, so row parity equals (row - P) parity and the
                    // toggle starts at 0 on the first start row.
                    wgroup_s = hold_row_s ? 4'd0 : {3'd0, row_r[0]};
                end else if (wsize_r) begin
                    wgroup_s = {1'b0, k_r[3:1]};
                    wround_s = {2'd0, k_r[0]};
                end else begin
                    wgroup_s = k_r;
                end
                if (row_r == 4'd15) begin
                    row_next   = 4'd0;
                    k_next     = k_inc_s;
                    state_next = (k_inc_s == npass_r) ? S_DRAIN : S_PASS;
                end else begin
                    row_next = row_r + 4'd1;
                end
            end
            S_DRAIN: begin
                if (drain_r == DRAIN_LAST) begin
                    drain_next = {DRAIN_W{1'b0}};
                    state_next = S_END;
                end else begin
                    drain_next = drain_r + DRAIN_W'(1);
                end
            end
            S_END: begin
                // Leaving on finish: the IDLE cycle already shows hold.
                if (ipf_finish) begin
                    state_next = S_IDLE;
                    done_s     = 1'b1;
                    ctrl_s     = CTRL_HOLD;
                end else begin
                    ctrl_s     = CTRL_END;
                end
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // State, counters, latched job configuration and registered IPF fields.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= S_IDLE;
            w_cnt_r   <= {W_ADDR_W{1'b0}};
            row_r     <= 4'd0;
            k_r       <= 4'd0;
            drain_r   <= {DRAIN_W{1'b0}};
            wsize_r   <= 1'b0;
            stride_r  <= 1'b0;
            npass_r   <= 4'd0;
            pad_r     <= 2'd0;
            w_valid_r <= 1'b0;
            i_valid_r <= 1'b0;
            done_r    <= 1'b0;
            ctrl_r    <= CTRL_HOLD;
            wgroup_r  <= 4'd0;
            wround_r  <= 3'd0;
        end else begin
            state_r   <= state_next;
            w_cnt_r   <= w_cnt_next;
            row_r     <= row_next;
            k_r       <= k_next;
            drain_r   <= drain_next;
            if (cfg_accept_s) begin
                wsize_r  <= cfg_wsize;
                stride_r <= cfg_stride;
                npass_r  <= cfg_npass;
                pad_r    <= cfg_pad;
            end
            w_valid_r <= w_valid_s;
            i_valid_r <= i_valid_s;
            done_r    <= done_s;
            ctrl_r    <= ctrl_s;
            wgroup_r  <= wgroup_s;
            wround_r  <= wround_s;
        end
    end

    assign cfg_ready = (state_r == S_IDLE);
    assign busy      = (state_r != S_IDLE);
    assign w_rd_en   = (state_r == S_LOAD_W);
    assign w_rd_addr = w_cnt_r;
    assign i_rd_en   = (state_r == S_PASS);
    assign i_rd_addr = I_ADDR_W'(row_r % 4'(ROWS));

    assign w_valid   = w_valid_r;
    assign w_data    = w_rd_data;
    assign i_valid   = i_valid_r;
    assign i_data    = i_rd_data;
    assign ctrl      = ctrl_r;
    assign wgroup    = wgroup_r;
    assign wround    = wround_r;
    assign Wsize     = {1'b0, wsize_r};
    assign stride    = stride_r;
    assign RLPadding = pad_r;
    assign done      = done_r;

endmodule

// File: doc/ipf_feeder.md
Name: ipf_feeder

Overview:
- Upstream sequencer for the IPF multiply engine.
- Fetches one kernel's weight words and an 8-row input tile from synchronous on-chip buffers.
- Drives IPF's w_valid/w_data, i_valid/i_data, ctrl, wgroup, wround, Wsize, stride and RLPadding with the exact per-pass schedule IPF requires.
- Waits for IPF finish, then reports done; replaces the hand-written stimulus sequences currently used to exercise IPF.

Parameters:
DATA_W, 64, width of weight and input words
W_ADDR_W, 5, weight buffer address width (holds up to 25 words)
I_ADDR_W, 3, input buffer address width
ROWS, 8, input rows per tile
DRAIN_CYC, 10, hold cycles after the last pass before ctrl=end

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-high
cfg_valid  in  1  config offered
cfg_ready  out  1  high only in IDLE; config accepted when cfg_valid&cfg_ready
cfg_wsize  in  1  0 = 3x3, 1 = 5x5
cfg_stride  in  1  0 = stride1, 1 = stride2
cfg_npass  in  4  number of passes (0 = none)
cfg_pad  in  2  RLPadding value for the job
w_rd_en  out  1  weight buffer read strobe
w_rd_addr  out  W_ADDR_W  weight buffer address
w_rd_data  in  DATA_W  weight data, valid 1 cycle after w_rd_en
i_rd_en  out  1  input buffer read strobe
i_rd_addr  out  I_ADDR_W  input buffer address
i_rd_data  in  DATA_W  input data, valid 1 cycle after i_rd_en
w_valid  out  1  to IPF
w_data  out  DATA_W  to IPF (wire from w_rd_data)
i_valid  out  1  to IPF
i_data  out  DATA_W  to IPF (wire from i_rd_data)
ctrl  out  2  to IPF: 0 end, 1 start, 2 hold
Wsize  out  2  to IPF: {1'b0, latched cfg_wsize}
stride  out  1  to IPF, latched
wgroup  out  4  to IPF
wround  out  3  to IPF
RLPadding  out  2  to IPF, latched cfg_pad
ipf_finish  in  1  IPF finish
busy  out  1  high from config accept until done
done  out  1  one-cycle pulse when the job completes

Behaviour:
- Reset values: all strobes/valids 0, addresses 0, ctrl=2, wgroup=0, wround=0, Wsize=0, stride=0, RLPadding=0, busy=0, done=0, cfg_ready=1; state IDLE. Reset mid-job aborts immediately, with no done pulse.
- Alignment: the FSM issues reads in cycle t. w_valid, i_valid, ctrl, wgroup and wround are registered copies of the cycle-t decisions, so they appear in t+1 together with the buffer data.
- Derived constants:
  - NW = 18 (3x3) or 25 (5x5).
  - P (preload rows) = 2 (3x3) or 4 (5x5).
  - Each pass streams 16 rows; row r reads address r mod 8.
- States:
  - IDLE: accept config, latch all cfg_* fields, go to LOAD_W.
  - LOAD_W: NW consecutive weight reads, addresses 0..NW-1; w_valid high for exactly NW cycles. Then go to PASS with pass k=0, or to DRAIN if cfg_npass=0.
  - PASS: rows 0..P-1 carry ctrl=2; rows P..15 carry ctrl=1; i_valid high for all 16 rows, with no gap between rows or passes. Per-pass fields:
    - 3x3 stride1: wgroup=k, wround=0.
    - 5x5 stride1: wgroup=k>>1, wround=k[0].
    - Stride2: wround=0; wgroup=0 on hold rows; during ctrl=1 rows wgroup toggles 0,1,0,1… starting at 0.
    - After row 15: k++; if k==cfg_npass go to DRAIN, else start the next pass.
  - DRAIN: i_valid=0, ctrl=2 for DRAIN_CYC cycles, then go to END.
  - END: ctrl=0 until ipf_finish is sampled high, then done=1 for one cycle and return to IDLE with ctrl=2 and busy=0.
- Rules and boundary cases:
  - w_valid and i_valid are never high in the same cycle.
  - cfg_valid is ignored while busy.
  - ipf_finish outside END is ignored.
  - wgroup is 4 bits, so k up to 15 is representable.

Test Plan:
- 3x3 stride1, npass=2, reset released: w_valid exactly 18 cycles with addr 0..17; pass0 gives 2 rows ctrl=2 then 14 rows ctrl=1 with wgroup=0; pass1 the same with wgroup=1; i_data order 0..7,0..7 per pass; then 10 hold cycles, ctrl=0; ipf_finish pulse → done one cycle later.
- 5x5 stride1, npass=4: w_valid 25 cycles; 4 hold rows per pass; (wgroup,wround) = (0,0),(0,1),(1,0),(1,1).
- 5x5 stride2, npass=1: wgroup sequence over 12 start rows is 0,1,0,1…; wround stays 0.
- npass=0: 18 weight loads, zero i_valid cycles, 10 hold, end; done follows ipf_finish.
- Assert rst during pass 1 row 7: all outputs return to reset values asynchronously with no done; a new cfg after release restarts from LOAD_W.
- cfg_valid held high while busy: no second accept; cfg_ready rises only after done.
